// File: rtl/product_accumulator.sv
// Dot-product accumulator: sums a vector of unsigned product beats and presents
// the sum, beat count and sticky overflow on a valid/ready result port.
// Optional feature macro ACC_SATURATE_EN: clamp the sum instead of wrapping.
module product_accumulator #(
  parameter int unsigned PRODUCT_WIDTH = 16,
  parameter int unsigned ACC_WIDTH     = 40,
  parameter int unsigned MAX_LEN       = 64,
  localparam int unsigned COUNT_WIDTH  = $clog2(MAX_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [PRODUCT_WIDTH-1:0] in_data,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_WIDTH-1:0]     out_data,
  output logic [COUNT_WIDTH-1:0]   out_count,
  output logic                     out_overflow
);

  localparam int unsigned SUM_WIDTH = ACC_WIDTH + 1;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic [ACC_WIDTH-1:0]   res_data_d;
  logic [COUNT_WIDTH-1:0] res_count_d;
  logic                   res_ovf_d;
  logic [SUM_WIDTH-1:0]   sum;
  logic [COUNT_WIDTH-1:0] count_inc;

  // Handshake flags come only from the state register (and reset), never from the peer.
  assign in_ready  = (state_q == ACCUM) && !reset;
  assign out_valid = (state_q == HOLD);

  // State, running sum and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ACCUM;
      acc_q        <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      out_data     <= '0;
      out_count    <= '0;
      out_overflow <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      out_data     <= res_data_d;
      out_count    <= res_count_d;
      out_overflow <= res_ovf_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    res_data_d  = out_data;
    res_count_d = out_count;
    res_ovf_d   = out_overflow;
    sum         = {1'b0, acc_q} + SUM_WIDTH'(in_data);
    count_inc   = count_q + COUNT_WIDTH'(1);

    case (state_q)
      ACCUM: begin
        if (in_valid) begin
          acc_d   = sum[ACC_WIDTH-1:0];
          ovf_d   = ovf_q | sum[ACC_WIDTH];
`ifdef ACC_SATURATE_EN
          // Once a carry has occurred the sum stays pinned at full scale.
          if (ovf_d) acc_d = '1;
`endif
          count_d = count_inc;
          if (in_last || (count_inc == COUNT_WIDTH'(MAX_LEN))) begin
            state_d     = HOLD;
            res_data_d  = acc_d;
            res_count_d = count_inc;
            res_ovf_d   = ovf_d;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACCUM;
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed self-checking bench for product_accumulator (16-bit sum, MAX_LEN=4
// so that forced termination and wrap/saturation are reachable with few beats).
module tb_product_accumulator;

  localparam int unsigned PW = 16;
  localparam int unsigned AW = 16;
  localparam int unsigned ML = 4;
  localparam int unsigned CW = $clog2(ML + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [PW-1:0] in_data;
  logic          in_last;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_data;
  logic [CW-1:0] out_count;
  logic          out_overflow;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  product_accumulator #(
    .PRODUCT_WIDTH(PW),
    .ACC_WIDTH    (AW),
    .MAX_LEN      (ML)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_count   (out_count),
    .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [PW-1:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 'x;
  endtask

  task automatic check_result(input string tag, input logic [AW-1:0] d,
                              input logic [CW-1:0] c, input logic o);
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".data"},  64'(out_data), 64'(d));
    check({tag, ".count"}, 64'(out_count), 64'(c));
    check({tag, ".ovf"},   64'(out_overflow), 64'(o));
    check({tag, ".ready"}, 64'(in_ready), 64'd0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();

    // Reset state
    check("rst.in_ready",  64'(in_ready), 64'd0);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.out_data",  64'(out_data), 64'd0);
    check("rst.out_count", 64'(out_count), 64'd0);
    check("rst.out_ovf",   64'(out_overflow), 64'd0);
    reset = 1'b0;
    tick();
    check("rel.in_ready", 64'(in_ready), 64'd1);

    // 3 + 5 + 7 = 15 over three beats, result valid exactly one cycle
    beat(16'd3, 1'b0);
    beat(16'd5, 1'b0);
    beat(16'd7, 1'b1);
    check_result("t1", 16'd15, 3'd3, 1'b0);
    tick();
    check("t1.valid_gone", 64'(out_valid), 64'd0);
    check("t1.ready_back", 64'(in_ready), 64'd1);

    // Single-beat vector, one bubble
    beat(16'h00FF, 1'b1);
    check_result("t2", 16'd255, 3'd1, 1'b0);
    tick();
    check("t2.ready_back", 64'(in_ready), 64'd1);

    // Forced termination at MAX_LEN; beat offered during HOLD is not taken
    in_valid = 1'b1;
    in_data  = 16'd1;
    in_last  = 1'b0;
    tick(); tick(); tick(); tick();
    check_result("t3a", 16'd4, 3'd4, 1'b0);
    tick();
    check("t3.ready_back", 64'(in_ready), 64'd1);
    tick(); tick();
    in_valid = 1'b0;
    check("t3.no_early", 64'(out_valid), 64'd0);
    beat(16'd5, 1'b1);
    check_result("t3b", 16'd7, 3'd3, 1'b0);
    tick();

    // Carry out of the 16-bit sum
    beat(16'hFFFF, 1'b0);
    beat(16'h0002, 1'b1);
`ifdef ACC_SATURATE_EN
    check_result("t4", 16'hFFFF, 3'd2, 1'b1);
`else
    check_result("t4", 16'h0001, 3'd2, 1'b1);
`endif
    tick();
    beat(16'd1, 1'b1);
    check_result("t4.ovf_cleared", 16'd1, 3'd1, 1'b0);
    tick();

    // Back-pressure: result held five cycles, upstream stalled
    out_ready = 1'b0;
    beat(16'd2, 1'b0);
    beat(16'd3, 1'b1);
    in_valid = 1'b1;
    in_data  = 16'd9;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_result("t5.hold", 16'd5, 3'd2, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("t5.valid_gone", 64'(out_valid), 64'd0);
    check("t5.ready_back", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_result("t5.resume", 16'd9, 3'd1, 1'b0);
    tick();

    // Reset mid-vector discards the partial sum
    beat(16'd7, 1'b0);
    beat(16'd7, 1'b0);
    reset = 1'b1;
    #1;
    check("t6.rst_ready", 64'(in_ready), 64'd0);
    check("t6.rst_valid", 64'(out_valid), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("t6.no_stale", 64'(out_valid), 64'd0);
    check("t6.ready", 64'(in_ready), 64'd1);
    beat(16'd4, 1'b0);
    beat(16'd4, 1'b1);
    check_result("t6", 16'd8, 3'd2, 1'b0);
    tick();
    check("t6.valid_gone", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
